muldiv_ctrl: RTL



---
 rtl/muldiv_if.sv | 28 ++
 rtl/muldiv_ctrl.sv | 92 +++++++++
 2 files changed

// File: rtl/muldiv_if.sv
// EX-stage multiply/divide bus: pipeline issue, divider handshake and HI/LO view.
interface muldiv_if;
  logic        ex_valid;
  logic [7:0]  ex_op;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic        flush;
  logic [63:0] div_result;
  logic        div_ready;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_opa;
  logic [31:0] div_opb;
  logic        div_annul;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport slave (
    input  ex_valid, ex_op, ex_a, ex_b, flush, div_result, div_ready,
    output div_start, div_signed, div_opa, div_opb, div_annul, stall, hi, lo
  );

  modport master (
    output ex_valid, ex_op, ex_a, ex_b, flush, div_result, div_ready,
    input  div_start, div_signed, div_opa, div_opb, div_annul, stall, hi, lo
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// HI/LO owner and mult/div sequencer; DIV/DIVU run on the external iterative divider.
// Optional MULDIV_DIVZERO_FAST_EN: zero-divisor divides commit at issue without the divider.
module muldiv_ctrl (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state;
  logic        issue;
  logic        is_div;
  logic        div_fast;
  logic [63:0] prod_s;
  logic [63:0] prod_u;

  assign issue  = (state == S_IDLE) && bus.ex_valid && !bus.flush;
  assign is_div = (bus.ex_op == EXE_DIV_OP) || (bus.ex_op == EXE_DIVU_OP);

`ifdef MULDIV_DIVZERO_FAST_EN
  assign div_fast = is_div && (bus.ex_b == 32'd0);
`else
  assign div_fast = 1'b0;
`endif

  // Low 64 bits of the sign-extended product equal the signed 32x32 product.
  assign prod_s = {{32{bus.ex_a[31]}}, bus.ex_a} * {{32{bus.ex_b[31]}}, bus.ex_b};
  assign prod_u = {32'd0, bus.ex_a} * {32'd0, bus.ex_b};

  assign bus.stall     = (state == S_BUSY) || (issue && is_div && !div_fast);
  assign bus.div_start = (state == S_BUSY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      bus.hi         <= 32'd0;
      bus.lo         <= 32'd0;
      bus.div_opa    <= 32'd0;
      bus.div_opb    <= 32'd0;
      bus.div_signed <= 1'b0;
      bus.div_annul  <= 1'b0;
    end else begin
      bus.div_annul <= 1'b0;
      case (state)
        S_IDLE: begin
          if (issue) begin
            case (bus.ex_op)
              EXE_MULT_OP:  {bus.hi, bus.lo} <= prod_s;
              EXE_MULTU_OP: {bus.hi, bus.lo} <= prod_u;
              EXE_MTHI_OP:  bus.hi <= bus.ex_a;
              EXE_MTLO_OP:  bus.lo <= bus.ex_a;
              EXE_DIV_OP, EXE_DIVU_OP: begin
                if (div_fast) begin
                  bus.hi <= bus.ex_a;
                  bus.lo <= 32'hFFFF_FFFF;
                end else begin
                  bus.div_opa    <= bus.ex_a;
                  bus.div_opb    <= bus.ex_b;
                  bus.div_signed <= (bus.ex_op == EXE_DIV_OP);
                  state          <= S_BUSY;
                end
              end
              default: ;
            endcase
          end
        end
        S_BUSY: begin
          // Flush wins over a same-cycle ready: the annulled result is dropped.
          if (bus.flush) begin
            bus.div_annul <= 1'b1;
            state         <= S_IDLE;
          end else if (bus.div_ready) begin
            {bus.hi, bus.lo} <= bus.div_result;
            state            <= S_DONE;
          end
        end
        // Divide still sits in EX here; ignore ex_op so it is not re-issued.
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
